// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, controller state encoding and funct classification shared
// by the execute controller and the ALU result select.
package alu_pkg;
   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLTU = 6'h2b;

   typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

   function automatic logic is_shift(input logic [5:0] f);
      return f == FUNCT_SLL || f == FUNCT_SRL || f == FUNCT_SRA;
   endfunction

   function automatic logic is_supported(input logic [5:0] f);
      return is_shift(f) || f == FUNCT_ADD || f == FUNCT_ADDU || f == FUNCT_SUB ||
             f == FUNCT_AND || f == FUNCT_OR || f == FUNCT_SLTU;
   endfunction
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies an R-type funct code for the execute controller.
module alu_seq_decode
   import alu_pkg::*;
(
   input  logic [5:0] funct,
   output logic       supported,
   output logic       shift,
   output logic       signed_arith
);
   assign supported    = is_supported(funct);
   assign shift        = is_shift(funct);
   assign signed_arith = funct == FUNCT_ADD || funct == FUNCT_SUB;
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle R-type execute controller with iterative 1-bit shifts.
// Define ALU_SEQ_FAST_SHIFT_EN to perform each shift in a single full-amount step.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int ALU_LAT   = 0,
   parameter int MAX_SHAMT = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_rs,
   input  logic [31:0] in_rt,
   output logic [5:0]  alu_funct,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_we,
   output logic        out_ovf,
   output logic        out_illegal
);
   state_t      state, state_d;
   logic [5:0]  funct_q;
   logic [4:0]  rd_q, cnt;
   logic [31:0] rs_q, rt_q, work_q;
   logic        shift_q, arith_q;
   logic [7:0]  lat_cnt;
   logic        dec_ok, dec_shift, dec_arith;
   logic        busy, cap, last, ovf, accept;
   logic [4:0]  shamt_c, step_amt;
   logic        unused;

   alu_seq_decode u_dec (
      .funct       (in_instr[5:0]),
      .supported   (dec_ok),
      .shift       (dec_shift),
      .signed_arith(dec_arith)
   );

   assign unused  = ^in_instr[31:16];
   assign shamt_c = 32'(in_instr[10:6]) > MAX_SHAMT ? 5'(MAX_SHAMT) : in_instr[10:6];
   assign accept  = in_valid && in_ready;
   assign busy    = state == EXEC || state == WAIT;
   assign cap     = (state == EXEC && ALU_LAT == 0) || (state == WAIT && lat_cnt == 0);
`ifdef ALU_SEQ_FAST_SHIFT_EN
   assign step_amt = cnt;
   assign last     = 1'b1;
`else
   assign step_amt = {4'b0, cnt != 0};
   assign last     = !shift_q || cnt <= 5'd1;
`endif
   assign ovf = arith_q && alu_result[31] != rs_q[31] &&
                (funct_q == FUNCT_SUB ? rs_q[31] != rt_q[31] : rs_q[31] == rt_q[31]);

   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign alu_funct = busy ? funct_q : 6'd0;
   assign alu_a     = busy && !shift_q ? rs_q : 32'd0;
   assign alu_b     = busy ? (shift_q ? work_q : rt_q) : 32'd0;
   assign alu_shamt = busy && shift_q ? step_amt : 5'd0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;

   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (in_valid) state_d = dec_ok ? EXEC : DONE;
         EXEC: state_d = ALU_LAT > 0 ? WAIT : (last ? DONE : EXEC);
         WAIT: state_d = lat_cnt != 0 ? WAIT : (last ? DONE : EXEC);
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         funct_q     <= '0;
         rd_q        <= '0;
         cnt         <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         work_q      <= '0;
         shift_q     <= 1'b0;
         arith_q     <= 1'b0;
         lat_cnt     <= '0;
         out_data    <= '0;
         out_rd      <= '0;
         out_we      <= 1'b0;
         out_ovf     <= 1'b0;
         out_illegal <= 1'b0;
      end else begin
         if (accept) begin
            funct_q     <= in_instr[5:0];
            rd_q        <= in_instr[15:11];
            cnt         <= shamt_c;
            rs_q        <= in_rs;
            rt_q        <= in_rt;
            work_q      <= in_rt;
            shift_q     <= dec_shift;
            arith_q     <= dec_arith;
            out_rd      <= in_instr[15:11];
            out_data    <= '0;
            out_we      <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= !dec_ok;
         end
         if (state == EXEC && ALU_LAT > 0) lat_cnt <= 8'(ALU_LAT - 1);
         else if (state == WAIT && lat_cnt != 0) lat_cnt <= lat_cnt - 8'd1;
         if (cap) begin
            work_q <= alu_result;
            if (cnt != 0) cnt <= cnt - 5'd1;
            if (last) begin
               out_data <= alu_result;
               out_ovf  <= ovf;
               out_we   <= rd_q != 0 && !ovf;
            end
         end
      end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed checks of alu_seq_ctrl against a behavioural ALU.
module tb_alu_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_rs = '0;
   logic [31:0] in_rt = '0;
   logic [5:0]  alu_funct;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_shamt;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_we, out_ovf, out_illegal;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs(in_rs), .in_rt(in_rt),
      .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rd(out_rd), .out_we(out_we), .out_ovf(out_ovf),
      .out_illegal(out_illegal)
   );

   always_comb begin
      alu_result = '0;
      case (alu_funct)
         6'h00: alu_result = alu_b << alu_shamt;
         6'h02: alu_result = alu_b >> alu_shamt;
         6'h03: alu_result = $unsigned($signed(alu_b) >>> alu_shamt);
         6'h20, 6'h21: alu_result = alu_a + alu_b;
         6'h22: alu_result = alu_a - alu_b;
         6'h24: alu_result = alu_a & alu_b;
         6'h25: alu_result = alu_a | alu_b;
         6'h2b: alu_result = {31'd0, alu_a < alu_b};
         default: alu_result = '0;
      endcase
   end

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] f);
      return {16'd0, rd, sh, f};
   endfunction

   task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_instr = instr; in_rs = rs; in_rt = rt;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic release_out();
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if ({out_data, out_rd, out_we, out_ovf, out_illegal} !== '0) begin bad++; $display("FAIL reset_out got=%h/%h/%b%b%b exp=0", out_data, out_rd, out_we, out_ovf, out_illegal); end
      total++; if ({alu_funct, alu_a, alu_b, alu_shamt} !== '0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h/%h exp=0", alu_funct, alu_a, alu_b, alu_shamt); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_arith();
      int lat;
      issue(mk(5'd5, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL add_ovf_lat got=%0d exp=2", lat); end
      total++; if (out_data !== 32'h80000000) begin bad++; $display("FAIL add_ovf_data got=%h exp=80000000", out_data); end
      total++; if ({out_ovf, out_we, out_illegal, out_rd} !== {3'b100, 5'd5}) begin bad++; $display("FAIL add_ovf_flags got=%b%b%b rd=%0d exp=100 rd=5", out_ovf, out_we, out_illegal, out_rd); end
      release_out();
      issue(mk(5'd9, 5'd0, 6'h20), 32'd5, 32'd7, lat);
      total++; if ({out_data, out_ovf, out_we} !== {32'd12, 2'b01}) begin bad++; $display("FAIL add_data got=%h ovf=%b we=%b exp=0000000c ovf=0 we=1", out_data, out_ovf, out_we); end
      release_out();
      issue(mk(5'd4, 5'd0, 6'h22), 32'h80000000, 32'd1, lat);
      total++; if ({out_data, out_ovf, out_we} !== {32'h7FFFFFFF, 2'b10}) begin bad++; $display("FAIL sub_ovf got=%h ovf=%b we=%b exp=7fffffff ovf=1 we=0", out_data, out_ovf, out_we); end
      release_out();
      issue(mk(5'd6, 5'd0, 6'h21), 32'h7FFFFFFF, 32'd1, lat);
      total++; if ({out_data, out_ovf, out_we} !== {32'h80000000, 2'b01}) begin bad++; $display("FAIL addu got=%h ovf=%b we=%b exp=80000000 ovf=0 we=1", out_data, out_ovf, out_we); end
      release_out();
      issue(mk(5'd0, 5'd0, 6'h2b), 32'd1, 32'hFFFFFFFF, lat);
      total++; if ({out_data, out_ovf, out_we} !== {32'd1, 2'b00}) begin bad++; $display("FAIL sltu_rd0 got=%h ovf=%b we=%b exp=00000001 ovf=0 we=0", out_data, out_ovf, out_we); end
      release_out();
      issue(mk(5'd8, 5'd0, 6'h24), 32'hF0F0_1234, 32'h0FF0_FF00, lat);
      total++; if ({out_data, out_we} !== {32'h00F0_1200, 1'b1}) begin bad++; $display("FAIL and got=%h we=%b exp=00f01200 we=1", out_data, out_we); end
      release_out();
   endtask

   task automatic test_shift();
      int lat;
      issue(mk(5'd3, 5'd4, 6'h03), 32'h80000000, 32'h80000000, lat);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      total++; if (lat !== 2) begin bad++; $display("FAIL sra_lat got=%0d exp=2", lat); end
`else
      total++; if (lat !== 5) begin bad++; $display("FAIL sra_lat got=%0d exp=5", lat); end
`endif
      total++; if ({out_data, out_we, out_ovf} !== {32'hF8000000, 2'b10}) begin bad++; $display("FAIL sra_data got=%h we=%b ovf=%b exp=f8000000 we=1 ovf=0", out_data, out_we, out_ovf); end
      release_out();
      issue(mk(5'd2, 5'd0, 6'h02), 32'd0, 32'h12345678, lat);
      total++; if ({out_data, lat} !== {32'h12345678, 32'd2}) begin bad++; $display("FAIL srl_sh0 got=%h lat=%0d exp=12345678 lat=2", out_data, lat); end
      release_out();
      issue(mk(5'd1, 5'd31, 6'h00), 32'd0, 32'd1, lat);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      total++; if ({out_data, lat} !== {32'h80000000, 32'd2}) begin bad++; $display("FAIL sll31 got=%h lat=%0d exp=80000000 lat=2", out_data, lat); end
`else
      total++; if ({out_data, lat} !== {32'h80000000, 32'd32}) begin bad++; $display("FAIL sll31 got=%h lat=%0d exp=80000000 lat=32", out_data, lat); end
`endif
      release_out();
      issue(mk(5'd7, 5'd8, 6'h02), 32'd0, 32'hF000_00FF, lat);
      total++; if (out_data !== 32'h00F0_0000) begin bad++; $display("FAIL srl8 got=%h exp=00f00000", out_data); end
      release_out();
   endtask

   task automatic test_illegal();
      int lat;
      issue(mk(5'd12, 5'd0, 6'h18), 32'd3, 32'd4, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL illegal_lat got=%0d exp=1", lat); end
      total++; if ({out_illegal, out_we, out_ovf, out_data} !== {3'b100, 32'd0}) begin bad++; $display("FAIL illegal_out got=%b%b%b data=%h exp=100 data=0", out_illegal, out_we, out_ovf, out_data); end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      int errs = 0;
      issue(mk(5'd7, 5'd0, 6'h25), 32'h0000_00F0, 32'h0000_000F, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 if (!out_valid || in_ready || out_data !== 32'hFF || out_rd !== 5'd7 || !out_we) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (data=%h valid=%b in_ready=%b)", errs, out_data, out_valid, in_ready); end
      release_out();
      total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_instr = mk(5'd9, 5'd20, 6'h00); in_rs = 32'd0; in_rt = 32'd1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_busy got in_ready=%b exp=0", in_ready); end
      rst_n = 1'b0;
      #1;
      total++; if ({in_ready, out_valid, alu_funct, alu_a, alu_b, alu_shamt} !== {2'b10, 75'd0}) begin bad++; $display("FAIL mid_reset_alu got rdy=%b v=%b b=%h sh=%0d exp=1/0/0/0", in_ready, out_valid, alu_b, alu_shamt); end
      total++; if ({out_data, out_rd, out_we, out_ovf, out_illegal} !== '0) begin bad++; $display("FAIL mid_reset_out got=%h/%h/%b%b%b exp=0", out_data, out_rd, out_we, out_ovf, out_illegal); end
      @(negedge clk) rst_n = 1'b1;
      issue(mk(5'd2, 5'd0, 6'h21), 32'd3, 32'd4, lat);
      total++; if ({out_data, out_rd, out_we, lat} !== {32'd7, 5'd2, 1'b1, 32'd2}) begin bad++; $display("FAIL after_reset got=%h rd=%0d we=%b lat=%0d exp=7 rd=2 we=1 lat=2", out_data, out_rd, out_we, lat); end
      release_out();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_shift();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle execute-stage controller for the R-type ALU datapath. The datapath is the per-function units plus the funct-keyed result selector.
- Accepts one R-type instruction with its operand values through a valid/ready handshake.
- Drives funct, operands and shamt into the ALU and captures the selected result.
- Sequences shifts iteratively, one bit per step, so a narrow shifter can be used.
- Presents the result with write-enable and trap flags to writeback through a second valid/ready handshake.

Parameters:
ALU_LAT, 0, extra wait cycles inserted per ALU step before the result is captured (0 = ALU is purely combinational).
MAX_SHAMT, 31, largest shift amount honoured; larger encodings are clamped (5-bit field, so effectively no clamp at default).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction/operands valid
in_ready  output  1  controller can accept
in_instr  input  32  R-type word: rd=[15:11], shamt=[10:6], funct=[5:0]
in_rs  input  32  rs register value
in_rt  input  32  rt register value
alu_funct  output  6  funct code to ALU result select
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_shamt  output  5  shift amount to ALU shifters
alu_result  input  32  selected ALU result (combinational from alu_* outputs)
out_valid  output  1  result valid
out_ready  input  1  writeback accepts
out_data  output  32  result
out_rd  output  5  destination register
out_we  output  1  register write enable
out_ovf  output  1  signed overflow trap (add/sub)
out_illegal  output  1  unsupported funct

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State = IDLE; in_ready=1; out_valid=0.
  - out_data=0, out_rd=0, out_we=0, out_ovf=0, out_illegal=0.
  - alu_funct=0, alu_a=0, alu_b=0, alu_shamt=0.
- Reset mid-operation aborts the instruction; no output is produced for it.
- Supported funct codes:
  - Shifts: 000000 sll, 000010 srl, 000011 sra.
  - Arithmetic: 100000 add, 100001 addu, 100010 sub.
  - Logic/compare: 100100 and, 100101 or, 101011 sltu.
- States: IDLE, EXEC, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch funct, rd, shamt, rs and rt (rt also loads the working register).
  - Unsupported funct: go to DONE with out_illegal=1, out_we=0, out_data=0.
  - Otherwise go to EXEC.
- EXEC:
  - Drive alu_funct = latched funct.
  - Non-shift operations: alu_a=rs, alu_b=rt, alu_shamt=0.
  - Shift operations: alu_b=working register, alu_shamt=1 (or 0 when latched shamt=0), alu_a=0.
  - If ALU_LAT>0, go to WAIT for ALU_LAT cycles holding the alu_* outputs; otherwise capture this cycle.
- Capture:
  - Non-shift: result → out_data; go to DONE.
  - Shift: result → working register; decrement the remaining count. At count 0 → DONE with out_data=working register, else stay in EXEC.
- Latency with ALU_LAT=0, accept at edge T:
  - out_valid asserts at T+2 for non-shift operations.
  - out_valid asserts at T+1+max(shamt,1) for shifts.
  - out_valid asserts at T+1 for illegal funct.
- DONE:
  - out_valid=1; all out_* held stable until out_ready.
  - On out_valid&&out_ready: return to IDLE (in_ready=1 the next cycle; no same-cycle re-accept).
- out_we = 1 unless any of the following: rd==0, illegal funct, or overflow trap.
- Overflow:
  - add/sub: out_ovf = signed overflow of rs±rt, computed from operand and result sign bits.
  - On overflow: out_ovf=1, out_we=0, out_data still carries the wrapped result.
  - addu, sltu and logic operations never set out_ovf.
- sra shifts in the sign bit on every step; sll/srl shift in zeros. shamt=0 returns rt unchanged after one EXEC step.
- in_valid while busy is ignored; the requester must hold it until in_ready.

Optional Feature:
ALU_SEQ_FAST_SHIFT_EN:
- Defined: shifts perform a single EXEC step with alu_shamt = full latched shamt, giving the same latency as non-shift operations.
- Undefined: iterative 1-bit stepping as above.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package alu_pkg holds:
  - FUNCT_* localparams for the nine codes.
  - The state encoding (IDLE/EXEC/WAIT/DONE).
  - An is_shift/is_supported function used by this block and by the ALU select.
- One combinational sub-module, alu_seq_decode: funct → {supported, is_shift, is_signed_arith}.
- The rest (FSM, step counter, latency counter, output registers) stays in the top.

Test Plan:
- add, rs=0x7FFFFFFF, rt=1, rd=5 → out_data=0x80000000, out_ovf=1, out_we=0, out_valid at T+2.
- sra, rt=0x80000000, shamt=4, rd=3 → out_data=0xF8000000, out_we=1; out_valid at T+5 (T+2 with ALU_SEQ_FAST_SHIFT_EN).
- sltu, rs=1, rt=0xFFFFFFFF, rd=0 → out_data=1, out_we=0 (rd zero).
- Illegal funct 011000 → out_valid at T+1, out_illegal=1, out_data=0, out_we=0.
- Backpressure: out_ready low 5 cycles in DONE → outputs stable, in_ready=0 throughout; accepted on release, in_ready=1 next cycle.
- Reset: deassert rst_n asynchronously mid-shift (shamt=20, step 7) → all outputs return to reset values immediately; next instruction executes correctly.
